huff_session_ctrl: RTL and testbench
====================================

// Module: huff_session_ctrl
// PURPOSE
//  Single-clock sequencer for one Huffman compression session.
//  - Captures UART RX bytes into the data RAM port A in the clk domain.
//  - Holds start to the Huffman core until it reports done.
//  - Optionally streams the 256-entry encoding table out to a UART TX byte interface.
//  - Sits between the UART RX/TX controllers, the data/encode RAMs and the Huffman core.
// PARAMETERS
//  MEM_DEPTH   102400  bytes captured per session
//  ADDR_W      17      data RAM address width (2**ADDR_W >= MEM_DEPTH)
//  ASCII_SIZE  256     encoding table entries
//  CODE_W      32      encoding word width (multiple of 8)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       async, active-high reset
//  rx_data      in   8       received byte
//  rx_valid     in   1       one-cycle strobe, rx_data valid
//  ram_we       out  1       data RAM port A write enable
//  ram_addr     out  ADDR_W  data RAM port A address
//  ram_din      out  8       data RAM port A write data
//  core_start   out  1       start level to Huffman core
//  core_done    in   1       core completion (level or pulse)
//  enc_en       out  1       encode RAM port B enable
//  enc_addr     out  8       encode RAM port B address
//  enc_dout     in   CODE_W  encode RAM read data, valid 1 clk after enc_en
//  tx_data      out  8       byte to UART TX
//  tx_valid     out  1       tx_data valid; held until tx_ready
//  tx_ready     in   1       TX accepts byte when tx_valid&tx_ready
//  rx_done      out  1       high from capture complete until session end
//  busy         out  1       high in every state except CAPTURE
//  err_overrun  out  1       sticky: byte arrived outside CAPTURE
// BEHAVIOUR
//  Reset (async): state=CAPTURE, addr=0, all outputs 0, err_overrun=0.
//  CAPTURE:
//   - On rx_valid: ram_we=1, ram_din=rx_data, ram_addr=cnt, all registered, 1 clk latency.
//   - cnt increments.
//   - When the byte at cnt==MEM_DEPTH-1 is written: cnt->0, rx_done=1, go to START.
//  START:
//   - core_start=1, go to WAIT_DONE.
//  WAIT_DONE:
//   - core_start stays 1 until core_done is sampled high.
//   - Next cycle: core_start=0, enter DUMP_RD (HUFF_CTRL_DUMP_EN) or FINISH.
//   - core_done already high on entry counts.
//  DUMP_RD:
//   - enc_en=1 for one clk with enc_addr=idx.
//   - Next clk, latch enc_dout into shift register; go to DUMP_TX.
//  DUMP_TX:
//   - Send CODE_W/8 bytes, MSB byte first.
//   - tx_valid held, tx_data stable until tx_ready.
//   - New byte presented the clk after each handshake.
//   - After the last byte: if idx==ASCII_SIZE-1 go to FINISH, else idx++ and go to DUMP_RD.
//  FINISH:
//   - One clk: rx_done=0, idx=0, cnt=0.
//   - Return to CAPTURE for the next session.
//  Boundaries:
//   - rx_valid outside CAPTURE: byte dropped, no RAM write, err_overrun=1 (cleared only by reset).
//   - rx_valid on the last-byte cycle: that byte is written; the transition still occurs.
//   - tx_ready high with tx_valid low: ignored.
//   - cnt never exceeds MEM_DEPTH-1.
//   - Reset mid-session from any state: immediate return to reset values; partial capture discarded.
// CONFIGURATION
//  HUFF_CTRL_DUMP_EN defined:
//   - DUMP_RD/DUMP_TX present; table streamed as above.
//  HUFF_CTRL_DUMP_EN undefined:
//   - WAIT_DONE goes directly to FINISH.
//   - enc_en, enc_addr, tx_valid, tx_data tied 0.
//   - tx_ready and enc_dout unused.
// TESTING
//  (MEM_DEPTH=8, ASCII_SIZE=4, CODE_W=32 unless stated)
//  1. Capture:
//     - Stimulus: bytes 0x10..0x17, one every 3 clks.
//     - Required: 8 writes at addr 0..7 with matching data.
//     - Required: rx_done=1 the clk after the 8th write; core_start=1 one clk later.
//  2. Start/done handshake:
//     - Stimulus: core_done asserted 20 clks after core_start.
//     - Required: core_start high exactly until 1 clk after core_done.
//     - Required: core_done high on entry is accepted on the first WAIT_DONE clk.
//  3. Dump (DUMP_EN):
//     - Stimulus: enc words 0xA1B2C3D4, 0x01020304, 0, 0xFFFFFFFF; tx_ready always 1.
//     - Required: TX bytes A1 B2 C3 D4 01 02 03 04 00 00 00 00 FF FF FF FF.
//     - Required: then FINISH, rx_done=0, busy=0.
//  4. Backpressure:
//     - Stimulus: tx_ready toggles 0/1 randomly.
//     - Required: same 16-byte sequence; tx_data stable while tx_valid&!tx_ready.
//  5. Overrun:
//     - Stimulus: byte 0x55 sent during WAIT_DONE.
//     - Required: no ram_we, err_overrun=1.
//     - Required: next session captures normally from addr 0.
//  6. Reset mid-dump:
//     - Stimulus: reset pulse during DUMP_TX byte 2.
//     - Required: all outputs 0 asynchronously; clean capture afterwards.
//     - Stimulus (no DUMP_EN): full session.
//     - Required: tx_valid never asserted.

Source files
------------

// File: rtl/huff_session_ctrl.sv
// rtl/huff_session_ctrl.sv - Huffman session sequencer: RX capture, core start/done, optional table dump
// Define HUFF_CTRL_DUMP_EN to stream the encoding table out of the UART TX byte interface.
module huff_session_ctrl #(
  parameter int MEM_DEPTH  = 102400,
  parameter int ADDR_W     = 17,
  parameter int ASCII_SIZE = 256,
  parameter int CODE_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              core_start,
  input  logic              core_done,
  output logic              enc_en,
  output logic [7:0]        enc_addr,
  input  logic [CODE_W-1:0] enc_dout,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              rx_done,
  output logic              busy,
  output logic              err_overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_CAPTURE,
    S_START,
    S_WAIT_DONE,
    S_DUMP_RD,
    S_DUMP_TX,
    S_FINISH
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              ram_we_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [7:0]        ram_din_nxt;
  logic              core_start_nxt;
  logic              rx_done_nxt;
  logic              err_overrun_nxt;

`ifdef HUFF_CTRL_DUMP_EN
  localparam int              NBYTES    = CODE_W / 8;
  localparam int              BC_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NBYTES - 1);
  localparam logic [7:0]      LAST_IDX  = 8'(ASCII_SIZE - 1);

  logic [7:0]        idx, idx_nxt;
  logic              enc_en_nxt;
  logic [7:0]        enc_addr_nxt;
  logic              tx_valid_nxt;
  logic [7:0]        tx_data_nxt;
  logic [CODE_W-1:0] shreg, shreg_nxt, shreg_shift;
  logic [BC_W-1:0]   byte_cnt, byte_cnt_nxt;
  // rd_wait marks the second DUMP_RD cycle, when enc_dout is valid
  logic              rd_wait, rd_wait_nxt;

  assign shreg_shift = shreg << 8;
`endif

  assign busy = (state != S_CAPTURE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_CAPTURE;
      cnt         <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      core_start  <= 1'b0;
      rx_done     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ram_we      <= ram_we_nxt;
      ram_addr    <= ram_addr_nxt;
      ram_din     <= ram_din_nxt;
      core_start  <= core_start_nxt;
      rx_done     <= rx_done_nxt;
      err_overrun <= err_overrun_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    ram_we_nxt      = 1'b0;
    ram_addr_nxt    = ram_addr;
    ram_din_nxt     = ram_din;
    core_start_nxt  = core_start;
    rx_done_nxt     = rx_done;
    // bytes outside CAPTURE are dropped and flagged until reset
    err_overrun_nxt = err_overrun | (rx_valid && (state != S_CAPTURE));
`ifdef HUFF_CTRL_DUMP_EN
    idx_nxt      = idx;
    enc_en_nxt   = 1'b0;
    enc_addr_nxt = enc_addr;
    tx_valid_nxt = tx_valid;
    tx_data_nxt  = tx_data;
    shreg_nxt    = shreg;
    byte_cnt_nxt = byte_cnt;
    rd_wait_nxt  = rd_wait;
`endif
    case (state)
      S_CAPTURE: begin
        if (rx_valid) begin
          ram_we_nxt   = 1'b1;
          ram_addr_nxt = cnt;
          ram_din_nxt  = rx_data;
          if (cnt == LAST_ADDR) begin
            cnt_nxt     = '0;
            rx_done_nxt = 1'b1;
            state_nxt   = S_START;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_START: begin
        core_start_nxt = 1'b1;
        state_nxt      = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (core_done) begin
          core_start_nxt = 1'b0;
`ifdef HUFF_CTRL_DUMP_EN
          enc_en_nxt   = 1'b1;
          enc_addr_nxt = idx;
          rd_wait_nxt  = 1'b0;
          state_nxt    = S_DUMP_RD;
`else
          state_nxt = S_FINISH;
`endif
        end
      end
`ifdef HUFF_CTRL_DUMP_EN
      S_DUMP_RD: begin
        if (!rd_wait) begin
          rd_wait_nxt = 1'b1;
        end else begin
          rd_wait_nxt  = 1'b0;
          shreg_nxt    = enc_dout;
          tx_data_nxt  = enc_dout[CODE_W-1 -: 8];
          tx_valid_nxt = 1'b1;
          byte_cnt_nxt = '0;
          state_nxt    = S_DUMP_TX;
        end
      end
      S_DUMP_TX: begin
        if (tx_valid && tx_ready) begin
          if (byte_cnt == LAST_BYTE) begin
            tx_valid_nxt = 1'b0;
            tx_data_nxt  = '0;
            if (idx == LAST_IDX) begin
              state_nxt = S_FINISH;
            end else begin
              idx_nxt      = idx + 1'b1;
              enc_en_nxt   = 1'b1;
              enc_addr_nxt = idx + 1'b1;
              state_nxt    = S_DUMP_RD;
            end
          end else begin
            shreg_nxt    = shreg_shift;
            tx_data_nxt  = shreg_shift[CODE_W-1 -: 8];
            byte_cnt_nxt = byte_cnt + 1'b1;
          end
        end
      end
`endif
      S_FINISH: begin
        rx_done_nxt = 1'b0;
        cnt_nxt     = '0;
`ifdef HUFF_CTRL_DUMP_EN
        idx_nxt = '0;
`endif
        state_nxt = S_CAPTURE;
      end
      default: state_nxt = S_CAPTURE;
    endcase
  end

`ifdef HUFF_CTRL_DUMP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      enc_en   <= 1'b0;
      enc_addr <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      shreg    <= '0;
      byte_cnt <= '0;
      rd_wait  <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      enc_en   <= enc_en_nxt;
      enc_addr <= enc_addr_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      shreg    <= shreg_nxt;
      byte_cnt <= byte_cnt_nxt;
      rd_wait  <= rd_wait_nxt;
    end
  end
`else
  assign enc_en   = 1'b0;
  assign enc_addr = '0;
  assign tx_valid = 1'b0;
  assign tx_data  = '0;

  localparam int unused_ascii_size = ASCII_SIZE;
  logic unused_dump_inputs;
  assign unused_dump_inputs = ^{tx_ready, enc_dout};
`endif

endmodule

// File: tb/tb_huff_session_ctrl.sv
// tb/tb_huff_session_ctrl.sv - self-checking bench for huff_session_ctrl
module tb_huff_session_ctrl;
  localparam int MEM_DEPTH  = 8;
  localparam int ADDR_W     = 3;
  localparam int ASCII_SIZE = 4;
  localparam int CODE_W     = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              core_start;
  logic              core_done;
  logic              enc_en;
  logic [7:0]        enc_addr;
  logic [CODE_W-1:0] enc_dout = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              rx_done;
  logic              busy;
  logic              err_overrun;

  always #5 clk = ~clk;

  huff_session_ctrl #(
    .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .ASCII_SIZE(ASCII_SIZE), .CODE_W(CODE_W)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .core_start(core_start), .core_done(core_done),
    .enc_en(enc_en), .enc_addr(enc_addr), .enc_dout(enc_dout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_done(rx_done), .busy(busy), .err_overrun(err_overrun)
  );

  // encode RAM model: one clock read latency
  logic [31:0] enc_tab [ASCII_SIZE];
  always @(posedge clk) if (enc_en) enc_dout <= enc_tab[enc_addr[1:0]];

  typedef struct { logic [7:0] data; int gap; } cap_vec_t;
  typedef struct { logic [31:0] word; logic [7:0] b0, b1, b2, b3; } enc_vec_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] data; } wr_t;

  int total = 0;
  int passed = 0;

  wr_t        wr_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] exp_wr[$];
  int         stall_viol = 0;
  int         tx_valid_seen = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (ram_we) wr_q.push_back('{ram_addr, ram_din});
    if (enc_en) rd_q.push_back(enc_addr);
    if (tx_valid) tx_valid_seen++;
    if (prev_stall && !(tx_valid && tx_data == prev_data)) stall_viol++;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] out_vec();
    return {30'b0, ram_we, ram_addr, ram_din, core_start, enc_en, enc_addr,
            tx_data, tx_valid, rx_done, busy, err_overrun};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic capture_random();
    logic [7:0] b;
    exp_wr.delete();
    for (int i = 0; i < MEM_DEPTH; i++) begin
      b = 8'($urandom);
      exp_wr.push_back(b);
      send(b);
      if (i < MEM_DEPTH - 1) repeat ($urandom_range(0, 3)) step();
    end
    chk("rx_done_after_last", rx_done, 1);
  endtask

  task automatic check_writes();
    chk("wr_count", wr_q.size(), MEM_DEPTH);
    for (int i = 0; i < wr_q.size() && i < MEM_DEPTH; i++) begin
      chk("wr_addr", wr_q[i].addr, i);
      chk("wr_data", wr_q[i].data, exp_wr[i]);
    end
  endtask

  task automatic check_tx_model();
    logic [31:0] w;
    chk("tx_count", tx_q.size(), ASCII_SIZE * 4);
    for (int e = 0; e < ASCII_SIZE; e++) begin
      w = enc_tab[e];
      for (int k = 0; k < 4; k++)
        if (e * 4 + k < tx_q.size())
          chk("tx_byte", tx_q[e * 4 + k], (w >> (8 * (3 - k))) & 32'hFF);
    end
  endtask

  task automatic wait_idle(input bit rand_ready);
    int n = 0;
    while (busy && n < 500) begin
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    chk("session_end_timeout", busy, 0);
    chk("rx_done_cleared", rx_done, 0);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    tx_q.delete();
    rd_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cap_vec_t cap_tab [MEM_DEPTH];
    enc_vec_t vt [ASCII_SIZE];
    int hi;
    int n;

    vt[0] = '{32'hA1B2C3D4, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    vt[1] = '{32'h01020304, 8'h01, 8'h02, 8'h03, 8'h04};
    vt[2] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[3] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < ASCII_SIZE; i++) enc_tab[i] = vt[i].word;
    for (int i = 0; i < MEM_DEPTH; i++) cap_tab[i] = '{8'(8'h10 + i), 2};

    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; core_done = 1'b0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", out_vec(), 0);
    reset = 1'b0;
    step();

    // session 1: directed capture, long core, overrun during WAIT_DONE, full-speed dump
    exp_wr.delete();
    for (int i = 0; i < MEM_DEPTH; i++) begin
      exp_wr.push_back(cap_tab[i].data);
      send(cap_tab[i].data);
      if (i == 3) chk("busy_in_capture", busy, 0);
      if (i == MEM_DEPTH - 1) begin
        chk("last_write_we", ram_we, 1);
        chk("rx_done_after_last", rx_done, 1);
        chk("core_start_not_yet", core_start, 0);
        step();
        chk("core_start_rise", core_start, 1);
        chk("busy_after_capture", busy, 1);
      end else begin
        repeat (cap_tab[i].gap) step();
      end
    end
    check_writes();
    chk("overrun_clear_before", err_overrun, 0);

    hi = 1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) begin rx_data = 8'h55; rx_valid = 1'b1; end
      step();
      rx_valid = 1'b0;
      if (k == 5) begin
        chk("overrun_no_we", ram_we, 0);
        chk("overrun_flag", err_overrun, 1);
      end
      if (core_start) hi++;
    end
    chk("overrun_no_extra_write", wr_q.size(), MEM_DEPTH);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("core_start_high_cycles", hi, 21);
    chk("core_start_fall", core_start, 0);
`ifdef HUFF_CTRL_DUMP_EN
    chk("first_enc_en", enc_en, 1);
    chk("first_enc_addr", enc_addr, 0);
    wait_idle(1'b0);
    chk("dump_tx_count", tx_q.size(), ASCII_SIZE * 4);
    for (int e = 0; e < ASCII_SIZE; e++) begin
      if (tx_q.size() >= 4 * e + 4) begin
        chk("dump_b0", tx_q[4 * e + 0], vt[e].b0);
        chk("dump_b1", tx_q[4 * e + 1], vt[e].b1);
        chk("dump_b2", tx_q[4 * e + 2], vt[e].b2);
        chk("dump_b3", tx_q[4 * e + 3], vt[e].b3);
      end
    end
    chk("enc_read_count", rd_q.size(), ASCII_SIZE);
    for (int e = 0; e < rd_q.size() && e < ASCII_SIZE; e++) chk("enc_read_addr", rd_q[e], e);
`else
    chk("no_dump_enc_en", enc_en, 0);
    wait_idle(1'b0);
`endif

    // session 2: random bytes, core_done high on WAIT_DONE entry, random backpressure
    clear_mon();
    for (int i = 0; i < ASCII_SIZE; i++) enc_tab[i] = $urandom;
    core_done = 1'b1;
    capture_random();
    step();
    chk("s2_core_start_rise", core_start, 1);
    step();
    chk("s2_done_on_entry", core_start, 0);
    core_done = 1'b0;
    wait_idle(1'b1);
    check_writes();
`ifdef HUFF_CTRL_DUMP_EN
    check_tx_model();
`endif
    chk("tx_stable_under_stall", stall_viol, 0);
    chk("overrun_sticky", err_overrun, 1);

    // session 3: reset mid-dump (or mid-wait without dump), then clean session
    clear_mon();
    enc_tab[0] = 32'hA1B2C3D4;
    capture_random();
`ifdef HUFF_CTRL_DUMP_EN
    core_done = 1'b1;
    step();
    step();
    core_done = 1'b0;
    tx_ready = 1'b1;
    n = 0;
    while (tx_q.size() < 2 && n < 100) begin step(); n++; end
    tx_ready = 1'b0;
    chk("mid_dump_valid", tx_valid, 1);
    chk("mid_dump_byte2", tx_data, 8'hC3);
`else
    step();
    step();
    chk("wait_done_hold", core_start, 1);
`endif
    #1 reset = 1'b1;
    #1 chk("async_reset_outputs", out_vec(), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    clear_mon();
    step();
    capture_random();
    step();
    check_writes();
    core_done = 1'b1;
    step();
    step();
    core_done = 1'b0;
    wait_idle(1'b1);
`ifdef HUFF_CTRL_DUMP_EN
    check_tx_model();
    chk("tx_stable_final", stall_viol, 0);
`else
    chk("no_dump_tx_valid_never", tx_valid_seen, 0);
    chk("no_dump_enc_reads", rd_q.size(), 0);
`endif
    chk("overrun_cleared_by_reset", err_overrun, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
